// File: rtl/usr_deser.sv
// Serial-to-parallel deserializer with per-word bit order, frame resync,
// valid/ready output handshake and a sticky overrun flag.
module usr_deser #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             frame_start,
  input  logic             dir,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    count;
  logic             dir_l;

  logic             start;
  logic             use_dir;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] shifted;
  logic             complete;

  // A word starts on any accepted bit at count 0 or on a frame_start resync;
  // starting from a cleared register keeps aborted bits out of the new word.
  always_comb begin
    start    = (count == '0) || frame_start;
    use_dir  = start ? dir : dir_l;
    base     = start ? '0 : sreg;
    shifted  = use_dir ? {sin, base[WIDTH-1:1]} : {base[WIDTH-2:0], sin};
    complete = sin_valid && !start && (count == CW'(WIDTH - 1));
  end

  assign busy = (count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg       <= '0;
      count      <= '0;
      dir_l      <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= sin_valid && frame_start && (count != '0);

      if (sin_valid) begin
        sreg  <= shifted;
        dir_l <= use_dir;
        if (start)
          count <= CW'(1);
        else if (complete)
          count <= '0;
        else
          count <= count + CW'(1);
      end

      // A consumer handshake on the completion edge frees the slot for the new word.
      if (complete) begin
        if (!dout_valid || dout_ready) begin
          dout       <= shifted;
          dout_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule
